// File: rtl/qlearn_pipe_param.sv
// Parametrised grid-world Q-learning engine: table clear after reset, 3-stage update pipe with forwarding.
// Build macro QL_LFSR_EN: take actions from an internal 16-bit LFSR instead of the act input.
module qlearn_pipe_param #(
   parameter int XBITS = 3,
   parameter int YBITS = 3,
   parameter int QW    = 16,
   parameter int FRAC  = 8,
   parameter logic signed [QW-1:0] ALPHA = 16'h0020,
   parameter logic signed [QW-1:0] GAMMA = 16'h00E6,
   parameter logic [XBITS+YBITS-1:0] START_STATE = '0,
   parameter logic [XBITS+YBITS-1:0] GOAL_STATE  = '1
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          act_valid,
   input  logic [1:0]                    act,
   output logic                          act_ready,
   input  logic                          rw_en,
   input  logic [XBITS+YBITS+1:0]        rw_addr,
   input  logic signed [QW-1:0]          rw_data,
   output logic [XBITS+YBITS-1:0]        cur_state,
   output logic                          upd_valid,
   output logic [XBITS+YBITS-1:0]        upd_state,
   output logic [1:0]                    upd_action,
   output logic signed [QW-1:0]          upd_q,
   output logic                          episode_done,
   output logic [15:0]                   ep_count
);
   localparam int SW = XBITS + YBITS;
   localparam int AW = SW + 2;
   localparam int WW = 2*QW + 2;
   localparam logic signed [WW-1:0] SAT_HI = {{(WW-QW+1){1'b0}}, {(QW-1){1'b1}}};
   localparam logic signed [WW-1:0] SAT_LO = {{(WW-QW+1){1'b1}}, {(QW-1){1'b0}}};

   typedef enum logic {S_INIT, S_RUN} fsm_t;

   fsm_t                 fsm_q;
   logic [AW-1:0]        clr_addr_q;
   logic [SW-1:0]        cur_state_q;
   logic                 episode_done_q;
   logic [15:0]          ep_count_q;
   logic                 v1_q, v2_q, v3_q;
   logic [SW-1:0]        s1_q, n1_q, s2_q, s3_q;
   logic [1:0]           a1_q, a2_q, a3_q;
   logic signed [QW-1:0] q_raw_q, r_q, mxn_raw_q, mxs_raw_q;
   logic                 q_fw_q, mxn_fw_q, mxs_fw_q;
   logic signed [QW-1:0] q_fwv_q, mxn_fwv_q, mxs_fwv_q;
   logic signed [QW-1:0] q3_q, mx3_q;
   logic                 upd_valid_q;
   logic [SW-1:0]        upd_state_q;
   logic [1:0]           upd_action_q;
   logic signed [QW-1:0] upd_q_q;

   logic signed [QW-1:0] q_mem   [2**AW];
   logic signed [QW-1:0] r_mem   [2**AW];
   logic signed [QW-1:0] mxa_mem [2**SW];
   logic signed [QW-1:0] mxb_mem [2**SW];

   logic                 accept;
   logic [1:0]           act_sel;
   logic [XBITS-1:0]     cx;
   logic [YBITS-1:0]     cy;
   logic [SW-1:0]        nxt_state_d;
   logic signed [QW-1:0] q_eff, mxn_eff, mxs_eff, sum_d, diff_d, newq_d, mx_new_d;
   logic signed [WW-1:0] g_w, p_w;
   logic                 q_fw_d, mxn_fw_d, mxs_fw_d;
   logic signed [QW-1:0] q_fwv_d, mxn_fwv_d, mxs_fwv_d;
   logic                 q_we, r_we, mx_we;
   logic [AW-1:0]        q_wa, r_wa;
   logic [SW-1:0]        mx_wa;
   logic signed [QW-1:0] q_wd, r_wd, mx_wd;

   function automatic logic signed [WW-1:0] sx(input logic signed [QW-1:0] v);
      return {{(WW-QW){v[QW-1]}}, v};
   endfunction

   function automatic logic signed [QW-1:0] sat(input logic signed [WW-1:0] v);
      if (v > SAT_HI)      return {1'b0, {(QW-1){1'b1}}};
      else if (v < SAT_LO) return {1'b1, {(QW-1){1'b0}}};
      else                 return v[QW-1:0];
   endfunction

   assign act_ready = (fsm_q == S_RUN) && !rw_en;
   assign accept    = act_valid && act_ready;

`ifdef QL_LFSR_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;
   logic [15:0] lfsr_q;
   assign act_sel = lfsr_q[1:0];
   always_ff @(posedge clk) begin
      if (!rst)        lfsr_q <= LFSR_SEED;
      else if (accept) lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end
`else
   assign act_sel = act;
`endif

   always_comb begin
      cx = cur_state_q[SW-1:YBITS];
      cy = cur_state_q[YBITS-1:0];
      unique case (act_sel)
         2'b00: if (cy != '0) cy = cy - YBITS'(1);
         2'b01: if (cx != '0) cx = cx - XBITS'(1);
         2'b10: if (cy != '1) cy = cy + YBITS'(1);
         2'b11: if (cx != '1) cx = cx + XBITS'(1);
      endcase
      nxt_state_d = {cx, cy};
   end

   // Forwarded values already include every older op, so they replace the raw table read outright.
   always_comb begin
      q_eff    = q_fw_q   ? q_fwv_q   : q_raw_q;
      mxn_eff  = mxn_fw_q ? mxn_fwv_q : mxn_raw_q;
      mxs_eff  = mxs_fw_q ? mxs_fwv_q : mxs_raw_q;
      g_w      = (sx(GAMMA) * sx(mxn_eff)) >>> FRAC;
      sum_d    = sat(sx(r_q) + g_w);
      diff_d   = sat(sx(sum_d) - sx(q_eff));
      p_w      = (sx(ALPHA) * sx(diff_d)) >>> FRAC;
      newq_d   = sat(sx(q_eff) + p_w);
      mx_new_d = (newq_d > mxs_eff) ? newq_d : mxs_eff;
   end

   always_comb begin
      q_fw_d = 1'b0;   q_fwv_d = q3_q;
      mxn_fw_d = 1'b0; mxn_fwv_d = mx3_q;
      mxs_fw_d = 1'b0; mxs_fwv_d = mx3_q;
      if (v2_q && {s2_q, a2_q} == {s1_q, a1_q}) begin
         q_fw_d = 1'b1; q_fwv_d = newq_d;
      end else if (v3_q && {s3_q, a3_q} == {s1_q, a1_q}) begin
         q_fw_d = 1'b1; q_fwv_d = q3_q;
      end
      if (v2_q && s2_q == n1_q) begin
         mxn_fw_d = 1'b1; mxn_fwv_d = mx_new_d;
      end else if (v3_q && s3_q == n1_q) begin
         mxn_fw_d = 1'b1; mxn_fwv_d = mx3_q;
      end
      if (v2_q && s2_q == s1_q) begin
         mxs_fw_d = 1'b1; mxs_fwv_d = mx_new_d;
      end else if (v3_q && s3_q == s1_q) begin
         mxs_fw_d = 1'b1; mxs_fwv_d = mx3_q;
      end
   end

   always_comb begin
      q_we  = v3_q && rst;  q_wa  = {s3_q, a3_q}; q_wd  = q3_q;
      mx_we = v3_q && rst;  mx_wa = s3_q;         mx_wd = mx3_q;
      r_we  = rw_en && rst; r_wa  = rw_addr;      r_wd  = rw_data;
      if (fsm_q == S_INIT) begin
         q_we  = 1'b1; q_wa  = clr_addr_q;           q_wd  = '0;
         mx_we = 1'b1; mx_wa = clr_addr_q[AW-1:2];   mx_wd = '0;
         r_we  = 1'b1; r_wa  = clr_addr_q;           r_wd  = '0;
      end
   end

   always_ff @(posedge clk) begin
      q_raw_q <= q_mem[{s1_q, a1_q}];
      r_q     <= r_mem[{s1_q, a1_q}];
      if (q_we) q_mem[q_wa] <= q_wd;
      if (r_we) r_mem[r_wa] <= r_wd;
   end

   always_ff @(posedge clk) begin
      mxn_raw_q <= mxa_mem[n1_q];
      mxs_raw_q <= mxb_mem[s1_q];
      if (mx_we) begin
         mxa_mem[mx_wa] <= mx_wd;
         mxb_mem[mx_wa] <= mx_wd;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         fsm_q          <= S_INIT;
         clr_addr_q     <= '0;
         cur_state_q    <= START_STATE;
         episode_done_q <= 1'b0;
         ep_count_q     <= '0;
         v1_q           <= 1'b0;
         v2_q           <= 1'b0;
         v3_q           <= 1'b0;
         upd_valid_q    <= 1'b0;
         upd_state_q    <= '0;
         upd_action_q   <= '0;
         upd_q_q        <= '0;
      end else begin
         if (fsm_q == S_INIT) begin
            clr_addr_q <= clr_addr_q + AW'(1);
            if (clr_addr_q == '1) fsm_q <= S_RUN;
         end
         episode_done_q <= 1'b0;
         v1_q           <= accept;
         if (accept) begin
            s1_q <= cur_state_q;
            a1_q <= act_sel;
            n1_q <= nxt_state_d;
            if (nxt_state_d == GOAL_STATE) begin
               cur_state_q    <= START_STATE;
               episode_done_q <= 1'b1;
               ep_count_q     <= ep_count_q + 16'd1;
            end else begin
               cur_state_q <= nxt_state_d;
            end
         end
         v2_q      <= v1_q;
         s2_q      <= s1_q;
         a2_q      <= a1_q;
         q_fw_q    <= q_fw_d;
         q_fwv_q   <= q_fwv_d;
         mxn_fw_q  <= mxn_fw_d;
         mxn_fwv_q <= mxn_fwv_d;
         mxs_fw_q  <= mxs_fw_d;
         mxs_fwv_q <= mxs_fwv_d;
         v3_q      <= v2_q;
         s3_q      <= s2_q;
         a3_q      <= a2_q;
         q3_q      <= newq_d;
         mx3_q     <= mx_new_d;
         upd_valid_q <= v3_q;
         if (v3_q) begin
            upd_state_q  <= s3_q;
            upd_action_q <= a3_q;
            upd_q_q      <= q3_q;
         end
      end
   end

   assign cur_state    = cur_state_q;
   assign episode_done = episode_done_q;
   assign ep_count     = ep_count_q;
   assign upd_valid    = upd_valid_q;
   assign upd_state    = upd_state_q;
   assign upd_action   = upd_action_q;
   assign upd_q        = upd_q_q;
endmodule

// File: doc/qlearn_pipe_param.md
Name: qlearn_pipe_param

Overview:
- Parametrised Q-learning update engine for a grid-world agent; next generation of the fixed 8x8 / 8-bit Q-learning pipeline.
- Generalised grid size, Q width and fixed-point format.
- Adds a valid/ready action handshake, a table-clear sequence after reset, programmable rewards, read-after-write forwarding, signed saturating arithmetic and episode (goal) handling.
- Holds the Q, Qmax and reward tables internally; sits between the action source and the policy/monitor logic.

Parameters:
XBITS, 3, grid row-index bits (state = {x,y}, x in upper bits)
YBITS, 3, grid column-index bits
QW, 16, signed Q/reward word width
FRAC, 8, fractional bits of all fixed-point values
ALPHA, 16'h0020, learning rate (0.125 at default FRAC)
GAMMA, 16'h00E6, discount factor (~0.898)
START_STATE, 0, state after reset and after reaching goal
GOAL_STATE, all ones, terminal state

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (sampled on rising clk; 0 = reset)
act_valid  in  1  action offered
act  in  2  action: 00 y-1, 01 x-1, 10 y+1, 11 x+1
act_ready  out  1  engine accepts action this cycle
rw_en  in  1  reward table write strobe
rw_addr  in  XBITS+YBITS+2  reward address {state,action}
rw_data  in  QW  signed reward
cur_state  out  XBITS+YBITS  current agent state
upd_valid  out  1  one-cycle pulse: Q update written
upd_state  out  XBITS+YBITS  state of written entry
upd_action  out  2  action of written entry
upd_q  out  QW  new Q value written
episode_done  out  1  one-cycle pulse when GOAL_STATE entered
ep_count  out  16  completed episodes, wraps at 16'hFFFF->0

Behaviour:
- Reset (rst=0 at an edge):
  - All outputs 0, except cur_state=START_STATE.
  - Pipeline valids cleared; in-flight ops are discarded, never written.
- FSM states:
  - INIT: clears Q, Qmax and R, one address per cycle (2^(XBITS+YBITS+2) cycles). act_ready=0. rw_en ignored.
  - RUN: entered after the last clear write.
  - Reset mid-INIT or mid-RUN returns to INIT at address 0.
- Accept: act_valid && act_ready at an edge (E0).
  - act_ready = RUN && !rw_en; a reward write has priority and blocks accept in that cycle.
  - rw_en in RUN writes R[rw_addr] at the edge.
- Next state s' from cur_state and act:
  - A move off the grid edge stays at s.
  - E0 registers {s, a, s'}. cur_state <= s', or START_STATE if s'==GOAL_STATE.
  - Back-to-back accepts are allowed every cycle.
- Pipeline:
  - E0+1: synchronous reads of Q[s,a], Qmax[s'] and R[s,a].
  - E0+2: new Q = Q + ((ALPHA*(r + ((GAMMA*qmax)>>>FRAC) - Q))>>>FRAC). Products are full width; >>> is arithmetic (truncation toward -inf). Each intermediate sum saturates to the signed QW range.
  - E0+3: write Q[s,a]=newQ. Write Qmax[s]=newQ if newQ > current Qmax[s] (signed); Qmax never decreases. upd_* valid in the following cycle.
  - Latency from accept to upd_valid: 3 edges.
- Forwarding:
  - Every Q/Qmax read returns the value the table would hold had all earlier accepted actions fully written back.
  - Compare against entries in the compute and writeback stages; the youngest match wins.
  - A Qmax forward applies the max rule.
- Episodes:
  - episode_done pulses in the cycle after the E0 whose s'==GOAL_STATE.
  - ep_count increments at that same edge.
  - The update for that op proceeds normally.
- Simultaneous Qmax updates to the same state in adjacent stages resolve in program order.

Optional Feature:
QL_LFSR_EN:
- Defined: act input is ignored. The action is lfsr[1:0] from an internal 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset), which advances on each accept. act_valid still gates acceptance.
- Undefined: no LFSR is built; the act port is used.

Test Plan:
- Reset with defaults, release rst -> act_ready=0 for 256 cycles, rises on cycle 256; all Q reads 0; cur_state=0.
- cur_state=0, act=00 (wall) -> cur_state stays 0; upd_state=0, upd_action=00, upd_q=16'h0000 3 edges later.
- R[{0,10}]=16'h0100; cur_state=0, act=10 -> cur_state=1; upd_q=16'h0020; Qmax[0]=16'h0020.
- Same setup, act=10 then act=00 on consecutive cycles -> second op forwards Qmax[0]=0x0020; second upd_q=16'h0003 (state 1, action 00).
- Walk from state 0 to 63 with no stalls -> episode_done single pulse, ep_count=1, cur_state=0 on the next cycle.
- Assert rst with 3 ops in flight -> no upd_valid pulses afterwards, INIT reruns, ep_count=0.
